// File: rtl/bcd_tick_counter.sv
// 1 s tick generator with a 4-digit packed-BCD up/down counter and debounced run/clear buttons.
// Optional build macro BCD_MMSS_EN turns the digits into an MM:SS clock (tens digits wrap at 5).
module bcd_tick_counter #(
  parameter int unsigned TICK_DIV        = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          RUN_AT_RESET    = 1'b1
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_clear,
  input  logic        up_down,
  output logic [15:0] bcd_digits,
  output logic        tick,
  output logic        rollover,
  output logic        running
);

  localparam int unsigned DW = $clog2(TICK_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BCD_MMSS_EN
  localparam logic [15:0] DIGIT_MAX = 16'h5959;
`else
  localparam logic [15:0] DIGIT_MAX = 16'h9999;
`endif

  // Per-button debounce: index 0 = run, index 1 = clear.
  logic [1:0]    raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    level;
  logic [1:0]    level_d;
  logic [CW-1:0] db_cnt [2];
  logic [1:0]    press;

  assign raw   = {btn_clear, btn_run};
  assign press = level & ~level_d;

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_d <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Returns {wrap, next}; each digit rolls at its own limit so one routine serves both builds.
  function automatic logic [16:0] bcd_step(input logic [15:0] d, input logic up);
    logic [15:0] next;
    logic [3:0]  nib;
    logic [3:0]  lim;
    logic        carry;
    next  = d;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      nib = d[4*i +: 4];
      lim = DIGIT_MAX[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (nib >= lim) nib = 4'd0;
          else begin
            nib   = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) nib = lim;
          else begin
            nib   = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
      next[4*i +: 4] = nib;
    end
    return {carry, next};
  endfunction

  logic [DW-1:0] div;
  logic [16:0]   step_val;

  always_comb begin
    step_val = bcd_step(bcd_digits, up_down);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      bcd_digits <= '0;
      tick       <= 1'b0;
      rollover   <= 1'b0;
      running    <= RUN_AT_RESET;
      div        <= '0;
    end else begin
      tick     <= 1'b0;
      rollover <= 1'b0;
      if (press[0]) running <= ~running;
      // Clear overrides a coincident step, suppressing its tick and rollover.
      if (press[1]) begin
        bcd_digits <= '0;
        div        <= '0;
      end else if (running) begin
        if (div == DIV_LAST) begin
          div        <= '0;
          bcd_digits <= step_val[15:0];
          tick       <= 1'b1;
          rollover   <= step_val[16];
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Define BCD_MMSS_EN for both files to exercise the MM:SS build.
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_run;
  logic        btn_clear;
  logic        up_down;
  logic [15:0] bcd_digits;
  logic        tick;
  logic        rollover;
  logic        running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bcd_tick_counter #(
    .TICK_DIV(4),
    .DEBOUNCE_CYCLES(3),
    .RUN_AT_RESET(1'b1)
  ) dut (
    .clock_100Mhz(clk),
    .reset(reset),
    .btn_run(btn_run),
    .btn_clear(btn_clear),
    .up_down(up_down),
    .bcd_digits(bcd_digits),
    .tick(tick),
    .rollover(rollover),
    .running(running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef BCD_MMSS_EN
  localparam logic [15:0] WRAP   = 16'h5959;
  localparam logic [15:0] WRAP_1 = 16'h5958;
  localparam logic [15:0] BORROW = 16'h0059;
`else
  localparam logic [15:0] WRAP   = 16'h9999;
  localparam logic [15:0] WRAP_1 = 16'h9998;
  localparam logic [15:0] BORROW = 16'h0099;
`endif

  // Monitors: log tick cycles and running transitions.
  int   tick_q[$];
  int   toggles = 0;
  int   fall_cyc = 0;
  int   rise_cyc = 0;
  logic run_prev = 1'b1;

  always @(negedge clk) begin
    if (tick === 1'b1) tick_q.push_back(cyc);
    if (reset === 1'b1 && running !== run_prev) begin
      toggles++;
      if (running) rise_cyc = cyc;
      else fall_cyc = cyc;
    end
    run_prev = running;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("tick_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic count_to(input logic [15:0] target);
    bit ok;
    ok = 1'b0;
    up_down = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (tick === 1'b1 && bcd_digits === target) begin
        ok = 1'b1;
        break;
      end
    end
    check("count_to", {31'd0, ok}, 32'd1);
  endtask

  int clr_lat = 0;

  task automatic press_clear();
    bit ok;
    int c;
    ok = 1'b0;
    c = cyc;
    btn_clear = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bcd_digits === 16'h0000) begin
        ok = 1'b1;
        clr_lat = cyc - c;
        break;
      end
    end
    check("clear_digits", {31'd0, ok}, 32'd1);
    repeat (4) @(negedge clk);
    btn_clear = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_run();
    btn_run = 1'b1;
    repeat (6) @(negedge clk);
    btn_run = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic        ud;
    logic [15:0] digits;
    logic        roll;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit          ok;
    int          rel;
    int          t0;
    int          d;
    int          tp;
    int          tr;
    int          tt;
    int          nticks;
    logic [15:0] snap;

    vecs[0] = '{1'b0, 16'h0001, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, WRAP,     1'b1};
    vecs[3] = '{1'b0, WRAP_1,   1'b0};
    vecs[4] = '{1'b1, WRAP,     1'b0};
    vecs[5] = '{1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 16'h0001, 1'b0};
    vecs[7] = '{1'b1, 16'h0002, 1'b0};

    reset = 1'b0;
    btn_run = 1'b0;
    btn_clear = 1'b0;
    up_down = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_digits", {16'd0, bcd_digits}, 32'h0000);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_rollover", {31'd0, rollover}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd1);
    reset = 1'b1;
    rel = cyc;

    wait_tick(ok);
    check("first_tick_delay", cyc - rel, 32'd4);
    check("first_tick_digits", {16'd0, bcd_digits}, 32'h0001);
    t0 = cyc;
    wait_tick(ok);
    check("tick_spacing", cyc - t0, 32'd4);
    check("second_digits", {16'd0, bcd_digits}, 32'h0002);

    for (int i = 0; i < 8; i++) begin
      up_down = vecs[i].ud;
      wait_tick(ok);
      check($sformatf("vec%0d_digits", i), {16'd0, bcd_digits}, {16'd0, vecs[i].digits});
      check($sformatf("vec%0d_rollover", i), {31'd0, rollover}, {31'd0, vecs[i].roll});
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), {30'd0, tick, rollover}, 32'd0);
    end

    // Direction change mid-count and multi-digit borrow.
    press_clear();
    count_to(16'h0129);
    up_down = 1'b0;
    wait_tick(ok);
    check("down_0128", {16'd0, bcd_digits}, 32'h0128);
    wait_tick(ok);
    check("down_0127", {16'd0, bcd_digits}, 32'h0127);
    press_clear();
    count_to(16'h0100);
    up_down = 1'b0;
    wait_tick(ok);
    check("borrow_0100", {16'd0, bcd_digits}, {16'd0, BORROW});
    up_down = 1'b1;
    check("running_after_clear", {31'd0, running}, 32'd1);

    // Bouncy run press: exactly one toggle.
    toggles = 0;
    btn_run = 1'b1;
    @(negedge clk);
    btn_run = 1'b0;
    @(negedge clk);
    btn_run = 1'b1;
    repeat (6) @(negedge clk);
    btn_run = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_toggles", toggles, 32'd1);
    check("paused", {31'd0, running}, 32'd0);
    tp = fall_cyc;
    t0 = 0;
    foreach (tick_q[i]) if (tick_q[i] <= tp) t0 = tick_q[i];
    d = (tp - t0) % 4;

    snap = bcd_digits;
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick === 1'b1) nticks++;
    end
    check("frozen_ticks", nticks, 32'd0);
    check("frozen_digits", {16'd0, bcd_digits}, {16'd0, snap});

    press_run();
    check("resumed", {31'd0, running}, 32'd1);
    tr = rise_cyc;
    tt = -1;
    foreach (tick_q[i]) if (tt < 0 && tick_q[i] > tr) tt = tick_q[i];
    check("resume_tick_cycle", tt, tr + (4 - d));

    // Clear press landing on a step cycle.
    wait_tick(ok);
    tt = cyc + 4;
    while (tt - clr_lat <= cyc + 1) tt += 4;
    while (cyc < tt - clr_lat) @(negedge clk);
    btn_clear = 1'b1;
    while (cyc < tt) @(negedge clk);
    check("clr_step_digits", {16'd0, bcd_digits}, 32'h0000);
    check("clr_step_tick", {31'd0, tick}, 32'd0);
    check("clr_step_rollover", {31'd0, rollover}, 32'd0);
    check("clr_step_running", {31'd0, running}, 32'd1);
    while (cyc < tt + 4) @(negedge clk);
    check("clr_div_tick", {31'd0, tick}, 32'd1);
    check("clr_div_digits", {16'd0, bcd_digits}, 32'h0001);
    btn_clear = 1'b0;
    repeat (10) @(negedge clk);

`ifdef BCD_MMSS_EN
    press_clear();
    count_to(16'h0058);
    wait_tick(ok);
    check("mmss_0059", {16'd0, bcd_digits}, 32'h0059);
    wait_tick(ok);
    check("mmss_0100", {16'd0, bcd_digits}, 32'h0100);
    check("mmss_0100_roll", {31'd0, rollover}, 32'd0);
    count_to(16'h1000);
    up_down = 1'b0;
    wait_tick(ok);
    check("mmss_0959", {16'd0, bcd_digits}, 32'h0959);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
